param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of one entry in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter AF_LVL, default DEPTH-2, almost_full asserts when count >= AF_LVL.
REQ-004 Parameter AE_LVL, default 2, almost_empty asserts when count <= AE_LVL.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 Port clr  in  1  synchronous flush, active-high.
REQ-008 Port wr_en  in  1  write request.
REQ-009 Port wr_data  in  DATA_W  write data.
REQ-010 Port rd_en  in  1  read request.
REQ-011 Port rd_data  out  DATA_W  registered read data.
REQ-012 Port rd_valid  out  1  rd_data holds a popped entry this cycle.
REQ-013 Port full, empty, almost_full, almost_empty  out  1 each  registered status flags.
REQ-014 Port count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 Port overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-016 Pointers SHALL be ADDR_W+1 bits; MSB is the wrap bit; the low ADDR_W bits index storage.
REQ-017 Write accepted iff wr_en && !full (flag value at the same edge); accepted write stores wr_data at wr_ptr and increments wr_ptr.
REQ-018 Read accepted iff rd_en && !empty; accepted read loads rd_data from rd_ptr on that edge (latency 1), asserts rd_valid the following cycle, increments rd_ptr.
REQ-019 rd_data SHALL hold its last value when no read is accepted; rd_valid = 0 then.
REQ-020 Simultaneous accepted read and write: both pointers advance, count unchanged; full and empty both unchanged.
REQ-021 When full, write-only is rejected even if rd_en is high in the same cycle (no write-through); when empty, read is rejected even if wr_en is high (no bypass).
REQ-022 count next = count + wr_acc - rd_acc; full = (count == DEPTH); empty = (count == 0); all flags registered from next-state values, no combinational path from inputs.
REQ-023 Pointer wrap: after DEPTH writes wr_ptr low bits return to 0 and wrap bit toggles; full iff low bits equal and wrap bits differ.
REQ-024 overflow pulses one cycle after wr_en while full; underflow pulses one cycle after rd_en while empty; state unchanged by rejected requests.
REQ-025 clr SHALL take priority over wr_en/rd_en: pointers and count to 0, empty=1, full=0, rd_valid=0; storage contents unspecified.

Reset
REQ-026 rst_n low asynchronously forces: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-027 Reset mid-operation discards all stored data; first accepted write after release lands at address 0.
REQ-028 Storage array SHALL NOT be reset.

Structure
REQ-029 Shared package fifo_pkg holds default parameter values and a function computing count width from ADDR_W.
REQ-030 One sub-module fifo_mem: DEPTH x DATA_W storage, one synchronous write port, one synchronous registered read port, no reset.
REQ-031 Control, pointers, count and flags SHALL reside in param_fifo; no FSM beyond the pointer/count registers.

Verification
REQ-032 Reset then 16 writes 0x00..0x0F (ADDR_W=4) -> full=1 after 16th edge, almost_full=1 at count 14, count=16.
REQ-033 From full, 17th write 0xAA -> overflow pulses 1 cycle, count stays 16, later reads return 0x00..0x0F in order, no 0xAA.
REQ-034 Empty, rd_en=1 -> underflow pulse, rd_valid=0, rd_data unchanged.
REQ-035 count=8, wr_en=rd_en=1 for 40 cycles with incrementing data -> count stays 8, pointers wrap twice, data order preserved.
REQ-036 count=5, assert clr with wr_en=1 -> count=0, empty=1 next cycle, written word not stored.
REQ-037 rst_n dropped mid-burst between edges -> flags/count reset immediately, not at next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and width helpers for the parameterised FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_AE_LVL = 2;

    // Occupancy spans 0..DEPTH inclusive, so it needs one bit more than an address.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: wrap-bit pointers, registered count and status flags,
// one-cycle read latency and overflow/underflow pulses.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_LVL = (1 << ADDR_W) - 2,
    parameter int AE_LVL = DEF_AE_LVL
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      rd_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [cnt_w(ADDR_W)-1:0]  count,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int CW = cnt_w(ADDR_W);
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_W);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);

    logic [CW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     wr_ptr_n, rd_ptr_n, count_n;
    logic              wr_acc, rd_acc;
    logic              full_n, empty_n;
    logic              have_data;
    logic [DATA_W-1:0] mem_q;

    assign wr_acc = wr_en && !full && !clr;
    assign rd_acc = rd_en && !empty && !clr;

    always_comb begin
        wr_ptr_n = wr_ptr + CW'(wr_acc);
        rd_ptr_n = rd_ptr + CW'(rd_acc);
        count_n  = count + CW'(wr_acc) - CW'(rd_acc);
        if (clr) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end
        full_n  = (wr_ptr_n[ADDR_W-1:0] == rd_ptr_n[ADDR_W-1:0])
               && (wr_ptr_n[ADDR_W] != rd_ptr_n[ADDR_W]);
        empty_n = (wr_ptr_n == rd_ptr_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
            have_data    <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            count        <= count_n;
            full         <= full_n;
            empty        <= empty_n;
            almost_full  <= (count_n >= AF_C);
            almost_empty <= (count_n <= AE_C);
            rd_valid     <= rd_acc;
            overflow     <= !clr && wr_en && full;
            underflow    <= !clr && rd_en && empty;
            if (rd_acc)
                have_data <= 1'b1;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (mem_q)
    );

    // Storage has no reset, so rd_data reads as zero until the first real pop.
    assign rd_data = have_data ? mem_q : '0;

    initial begin
        assert (DEPTH_C != '0);
    end

endmodule
